// File: rtl/mux4_rr_sampler_pkg.sv
// ============================================================================
// mux4_pkg : shared types, constants and round-robin helper for the sampler.
// Rev 1.0
// ============================================================================
`default_nettype none

package mux4_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } rr_state_t;

    // Nearest requester strictly after ptr wins; scanning far-to-near lets the
    // last hit be the closest one.
    function automatic sel_t rr_pick(input logic [NUM_CH-1:0] req, input sel_t ptr);
        sel_t idx;
        rr_pick = ptr;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = ptr + sel_t'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux4_rr_sampler_if.sv
// ============================================================================
// mux4_rr_sampler_if : valid/ready output stream carrying sample and channel.
// Rev 1.0
// ============================================================================
`default_nettype none

interface mux4_rr_sampler_if;
    import mux4_pkg::*;

    logic out_valid;
    logic out_ready;
    logic out_data;
    sel_t out_ch;

    modport master (output out_valid, output out_data, output out_ch, input  out_ready);
    modport slave  (input  out_valid, input  out_data, input  out_ch, output out_ready);

endinterface

`default_nettype wire

// File: rtl/mux4_rr_sampler_rr_arb4.sv
// ============================================================================
// rr_arb4 : combinational 4-way round-robin picker.
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb4
    import mux4_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  sel_t              ptr,
    output sel_t              grant,
    output logic              any_req
);

    assign grant   = rr_pick(req, ptr);
    assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/mux4_rr_sampler.sv
// ============================================================================
// mux4_rr_sampler : round-robin select driver and settle-timed sampler for mux4.
// Optional per-channel grant counters under MUX4_RR_SAMPLER_STATS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module mux4_rr_sampler
    import mux4_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      req,
    output logic [NUM_CH-1:0]      req_ack,
    output logic                   S1,
    output logic                   S0,
    input  logic                   Q,
    mux4_rr_sampler_if.master      out_if,
`ifdef MUX4_RR_SAMPLER_STATS_EN
    input  logic                   stats_clr,
    output logic [NUM_CH*CNT_W-1:0] grant_cnt,
`endif
    output logic                   busy
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("mux4_rr_sampler: SETTLE_CYCLES must be in 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("mux4_rr_sampler: CNT_W must be at least 1");
    end

    localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

    rr_state_t         r_state, w_state_nxt;
    sel_t              r_sel,   w_sel_nxt;
    sel_t              r_ptr,   w_ptr_nxt;
    logic [3:0]        r_cnt,   w_cnt_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_data,  w_data_nxt;
    sel_t              r_ch,    w_ch_nxt;
    logic [NUM_CH-1:0] r_ack,   w_ack_nxt;

    sel_t w_grant;
    logic w_any_req;
    logic w_capture;

    rr_arb4 u_arb (
        .req     (req),
        .ptr     (r_ptr),
        .grant   (w_grant),
        .any_req (w_any_req)
    );

    assign w_capture = (r_state == CAPTURE);

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_ch_nxt    = r_ch;
        w_ack_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = SETTLE;
                    w_sel_nxt   = w_grant;
                    w_cnt_nxt   = c_settle_load;
                end
            end
            SETTLE: begin
                if (r_cnt == 4'd0) w_state_nxt = CAPTURE;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            CAPTURE: begin
                w_data_nxt  = Q;
                w_ch_nxt    = r_sel;
                w_valid_nxt = 1'b1;
                w_ack_nxt   = NUM_CH'(1) << r_sel;
                w_ptr_nxt   = r_sel;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                // Acceptance and the next grant share one cycle so back-to-back
                // samples lose nothing.
                if (r_valid && out_if.out_ready) begin
                    w_valid_nxt = 1'b0;
                    if (w_any_req) begin
                        w_state_nxt = SETTLE;
                        w_sel_nxt   = w_grant;
                        w_cnt_nxt   = c_settle_load;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= sel_t'(NUM_CH - 1);
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= 1'b0;
            r_ch    <= '0;
            r_ack   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_ch    <= w_ch_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    assign S1               = r_sel[1];
    assign S0               = r_sel[0];
    assign req_ack          = r_ack;
    assign busy             = (r_state != IDLE);
    assign out_if.out_valid = r_valid;
    assign out_if.out_data  = r_data;
    assign out_if.out_ch    = r_ch;

`ifdef MUX4_RR_SAMPLER_STATS_EN
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt_ch;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_cnt_ch <= '0;
            else if (stats_clr)
                r_cnt_ch <= '0;
            else if (w_capture && r_sel == sel_t'(g) && r_cnt_ch != '1)
                r_cnt_ch <= r_cnt_ch + CNT_W'(1);
        end
        assign grant_cnt[g*CNT_W +: CNT_W] = r_cnt_ch;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_sampler.sv
// ============================================================================
// tb_mux4_rr_sampler : directed + randomized self-checking bench with a
// transaction-level round-robin reference model and a behavioural mux4.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux4_rr_sampler;
    import mux4_pkg::*;

    localparam int SETTLE = 2;
    localparam int CW     = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'd0;
    logic [3:0] x     = 4'd0;
    logic [3:0] req_ack;
    logic       S1, S0, Q, busy;

    mux4_rr_sampler_if oif ();

    // Behavioural mux4: Q = X[{S1,S0}]
    assign Q = x[{S1, S0}];

`ifdef MUX4_RR_SAMPLER_STATS_EN
    logic            stats_clr = 1'b0;
    logic [4*CW-1:0] grant_cnt;
    int              gc_m [4] = '{0, 0, 0, 0};
`endif

    always #5 clk = ~clk;

    mux4_rr_sampler #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_ack   (req_ack),
        .S1        (S1),
        .S0        (S0),
        .Q         (Q),
        .out_if    (oif),
`ifdef MUX4_RR_SAMPLER_STATS_EN
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ptr_m = 3;
    int   last_ch = 0;
    logic last_data = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spec rule: first requester strictly after the last granted channel.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant edge happens on the next clock; then settle, then capture.
    task automatic grant_cycle(input logic [3:0] r, input logic [3:0] xv, input string tag);
        int c;
        req = r;
        x   = xv;
        tick();
        c = pick(r, ptr_m);
        check($sformatf("%s_grant_sel", tag), 32'({S1, S0}), 32'(c));
        check($sformatf("%s_grant_busy", tag), 32'(busy), 32'd1);
        check($sformatf("%s_grant_valid", tag), 32'(oif.out_valid), 32'd0);
        oif.out_ready = 1'b0;
        req = 4'($urandom);
        for (int s = 0; s < SETTLE; s++) begin
            tick();
            check($sformatf("%s_settle_valid", tag), 32'(oif.out_valid), 32'd0);
            check($sformatf("%s_settle_sel", tag), 32'({S1, S0}), 32'(c));
        end
        tick();
        check($sformatf("%s_cap_valid", tag), 32'(oif.out_valid), 32'd1);
        check($sformatf("%s_cap_data", tag), 32'(oif.out_data), 32'(xv[c]));
        check($sformatf("%s_cap_ch", tag), 32'(oif.out_ch), 32'(c));
        check($sformatf("%s_cap_ack", tag), 32'(req_ack), 32'd1 << c);
        ptr_m     = c;
        last_ch   = c;
        last_data = xv[c];
`ifdef MUX4_RR_SAMPLER_STATS_EN
        if (gc_m[c] < (1 << CW) - 1) gc_m[c]++;
`endif
    endtask

    task automatic stall(input int k);
        for (int i = 0; i < k; i++) begin
            req = 4'($urandom);
            x   = 4'($urandom);
            tick();
            check("hold_valid", 32'(oif.out_valid), 32'd1);
            check("hold_data", 32'(oif.out_data), 32'(last_data));
            check("hold_ch", 32'(oif.out_ch), 32'(last_ch));
            check("hold_sel", 32'({S1, S0}), 32'(last_ch));
            check("hold_ack", 32'(req_ack), 32'd0);
        end
    endtask

    initial begin
        logic [3:0] r;
        oif.out_ready = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_sel", 32'({S1, S0}), 32'd0);
        check("rst_valid", 32'(oif.out_valid), 32'd0);
        check("rst_data", 32'(oif.out_data), 32'd0);
        check("rst_ch", 32'(oif.out_ch), 32'd0);
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request on channel 1 with X0..X3 = 0,1,0,1
        grant_cycle(4'b0010, 4'b1010, "single");
        stall(10);

        // Round robin with all requesting, accept every sample
        for (int i = 0; i < 5; i++) begin
            oif.out_ready = 1'b1;
            grant_cycle(4'b1111, 4'b1010, "rr");
        end

        // Reset in the middle of SETTLE
        oif.out_ready = 1'b1;
        req = 4'b0100;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_sel", 32'({S1, S0}), 32'd0);
        check("midrst_valid", 32'(oif.out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ack", 32'(req_ack), 32'd0);
        tick();
        check("midrst_ack2", 32'(req_ack), 32'd0);
        rst_n = 1'b1;
        ptr_m = 3;
`ifdef MUX4_RR_SAMPLER_STATS_EN
        for (int i = 0; i < 4; i++) gc_m[i] = 0;
`endif
        grant_cycle(4'b1000, 4'($urandom), "postrst");

        // Hog on channel 0 while channel 2 pulses
        oif.out_ready = 1'b1;
        grant_cycle(4'b0001, 4'($urandom), "hog");
        oif.out_ready = 1'b1;
        grant_cycle(4'b0101, 4'($urandom), "hog2");

        // Randomized traffic with backpressure and idle gaps
        for (int it = 0; it < 150; it++) begin
            stall(int'($urandom_range(0, 3)));
            r = 4'($urandom);
            if (r == 4'd0) begin
                req = 4'd0;
                oif.out_ready = 1'b1;
                x = 4'($urandom);
                tick();
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_valid", 32'(oif.out_valid), 32'd0);
                check("idle_sel", 32'({S1, S0}), 32'(last_ch));
                oif.out_ready = 1'($urandom);
                r = 4'($urandom_range(1, 15));
            end else begin
                oif.out_ready = 1'b1;
            end
            grant_cycle(r, 4'($urandom), "rnd");
        end

`ifdef MUX4_RR_SAMPLER_STATS_EN
        for (int i = 0; i < 4; i++)
            check($sformatf("stats_ch%0d", i), 32'(grant_cnt[i*CW +: CW]), 32'(gc_m[i]));
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("stats_clr", 32'(grant_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
